// File: rtl/instmem_pkg.sv
// Shared constants, state encoding and state-decode helpers for the instruction-memory loader.
package instmem_pkg;

   localparam int DEPTH_DEFAULT = 1024;
   localparam int WORD_W        = 32;
   localparam int BYTE_W        = 8;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_HDR   = 3'd1;
   localparam state_t ST_DATA  = 3'd2;
   localparam state_t ST_WRITE = 3'd3;
   localparam state_t ST_CSUM  = 3'd4;
   localparam state_t ST_DONE  = 3'd5;
   localparam state_t ST_ERR   = 3'd6;

   function automatic logic takes_bytes(input state_t s);
      logic r;
      case (s)
         ST_HDR, ST_DATA, ST_CSUM: r = 1'b1;
         default:                  r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_busy(input state_t s);
      logic r;
      case (s)
         ST_HDR, ST_DATA, ST_WRITE, ST_CSUM: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/instmem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: 2-bit byte counter, 24-bit shift register, word_valid on the 4th byte.
module byte_packer
   import instmem_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              accept,
   input  logic [BYTE_W-1:0] data,
   output logic [WORD_W-1:0] word,
   output logic              word_valid
);

   logic [1:0]  cnt_r;
   logic [23:0] shift_r;

   // the incoming byte lands on top, so the first byte ends up in [7:0]
   assign word       = {data, shift_r};
   assign word_valid = accept && (cnt_r == 2'd3);

   // byte counter and shift register, restarted on clr
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r   <= 2'd0;
         shift_r <= 24'd0;
      end else if (clr) begin
         cnt_r   <= 2'd0;
         shift_r <= 24'd0;
      end else if (accept) begin
         cnt_r   <= cnt_r + 2'd1;
         shift_r <= word[31:8];
      end else begin
         cnt_r   <= cnt_r;
         shift_r <= shift_r;
      end
   end

endmodule

// File: rtl/instmem_loader.sv
// Framed byte-stream loader driving the instmem write port; optional trailing XOR checksum
// enabled by defining IMLOAD_CHECKSUM_EN.
module instmem_loader
   import instmem_pkg::*;
#(
   parameter int DEPTH     = DEPTH_DEFAULT,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [BYTE_W-1:0] rx_data,
   output logic              rx_ready,
   output logic              im_write,
   output logic [WORD_W-1:0] im_addr,
   output logic [WORD_W-1:0] im_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [WORD_W-1:0] MAX_CNT = 32'(DEPTH - BASE_ADDR);
   localparam logic [WORD_W-1:0] BASE    = 32'(BASE_ADDR);

   state_t            state_r, state_nxt_s;
   logic [WORD_W-1:0] cnt_r, idx_r, im_addr_r, im_wdata_r, pk_word_s;
   logic              rx_ready_r, im_write_r, busy_r, done_r, err_r;
   logic              accept_s, start_ok_s, pk_valid_s, last_s;
`ifdef IMLOAD_CHECKSUM_EN
   logic [WORD_W-1:0] csum_r;
`endif

   assign accept_s   = rx_valid && rx_ready_r;
   assign start_ok_s = start && (state_r == ST_IDLE || state_r == ST_DONE || state_r == ST_ERR);
   assign last_s     = (idx_r == cnt_r - 32'd1);

   byte_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (start_ok_s),
      .accept     (accept_s),
      .data       (rx_data),
      .word       (pk_word_s),
      .word_valid (pk_valid_s)
   );

   // next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) state_nxt_s = ST_HDR;
            else       state_nxt_s = state_r;
         end
         ST_HDR: begin
            if (!pk_valid_s)                 state_nxt_s = ST_HDR;
            else if (pk_word_s == 32'd0)     state_nxt_s = ST_DONE;
            else if (pk_word_s > MAX_CNT)    state_nxt_s = ST_ERR;
            else                             state_nxt_s = ST_DATA;
         end
         ST_DATA: begin
            if (pk_valid_s) state_nxt_s = ST_WRITE;
            else            state_nxt_s = ST_DATA;
         end
         ST_WRITE: begin
`ifdef IMLOAD_CHECKSUM_EN
            if (last_s) state_nxt_s = ST_CSUM;
`else
            if (last_s) state_nxt_s = ST_DONE;
`endif
            else        state_nxt_s = ST_DATA;
         end
`ifdef IMLOAD_CHECKSUM_EN
         ST_CSUM: begin
            if (!pk_valid_s)               state_nxt_s = ST_CSUM;
            else if (pk_word_s == csum_r)  state_nxt_s = ST_DONE;
            else                           state_nxt_s = ST_ERR;
         end
`endif
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // state register; status outputs are decoded from the next state so they track state_r exactly
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         rx_ready_r <= 1'b0;
         im_write_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         rx_ready_r <= takes_bytes(state_nxt_s);
         im_write_r <= (state_nxt_s == ST_WRITE);
         busy_r     <= is_busy(state_nxt_s);
         done_r     <= (state_nxt_s == ST_DONE);
         err_r      <= (state_nxt_s == ST_ERR);
      end
   end

   // count, word index, write port and checksum datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r      <= 32'd0;
         idx_r      <= 32'd0;
         im_addr_r  <= 32'd0;
         im_wdata_r <= 32'd0;
`ifdef IMLOAD_CHECKSUM_EN
         csum_r     <= 32'd0;
`endif
      end else if (start_ok_s) begin
         cnt_r      <= 32'd0;
         idx_r      <= 32'd0;
`ifdef IMLOAD_CHECKSUM_EN
         csum_r     <= 32'd0;
`endif
      end else begin
         if (state_r == ST_HDR && pk_valid_s) begin
            cnt_r <= pk_word_s;
         end
         if (state_r == ST_DATA && pk_valid_s) begin
            im_addr_r  <= BASE + idx_r;
            im_wdata_r <= pk_word_s;
`ifdef IMLOAD_CHECKSUM_EN
            csum_r     <= csum_r ^ pk_word_s;
`endif
         end
         // idx stops at count-1, so the address never runs past the last loaded word
         if (state_r == ST_WRITE && !last_s) begin
            idx_r <= idx_r + 32'd1;
         end
      end
   end

   assign rx_ready = rx_ready_r;
   assign im_write = im_write_r;
   assign im_addr  = im_addr_r;
   assign im_wdata = im_wdata_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign err      = err_r;

endmodule
